// File: rtl/calc2_multiport_engine.sv
// calc2_multiport_engine: NUM_PORTS request ports sharing one round-robin add/sub unit and one shift unit
//   c_clk        clock, rising edge
//   reset        synchronous active-high
//   req_cmd_in   4-bit cmd per port, port p at [4p+3:4p]
//   req_data_in  operand per port (op1 with cmd, op2 on the following edge)
//   port_busy    port holds an outstanding request
//   out_resp     per-port response: 00 none, 01 ok, 10 input error, 11 internal error
//   out_data     per-port result, zero while out_resp is 00
module calc2_multiport_engine #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int SHAMT_W   = 5
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*4-1:0]        req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
    output logic [NUM_PORTS-1:0]          port_busy,
    output logic [NUM_PORTS*2-1:0]        out_resp,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    typedef enum logic [1:0] {IDLE, OP2, PEND} state_t;
    state_t            state [NUM_PORTS];
    logic [3:0]        cmd_r [NUM_PORTS];
    logic [DATA_W-1:0] op1   [NUM_PORTS];
    logic [DATA_W-1:0] op2   [NUM_PORTS];
    logic [NUM_PORTS-1:0] armed, rdy, req_as, req_sh, gnt_as, gnt_sh, done;
    logic [PW-1:0]        ptr_as, ptr_sh;
    function automatic logic is_as(input logic [3:0] c);
        return c == 4'd1 || c == 4'd2;
    endfunction
    function automatic logic is_sh(input logic [3:0] c);
        return c == 4'd5 || c == 4'd6;
    endfunction
    // descending scan so the requester closest to the pointer is written last and wins
    function automatic logic [NUM_PORTS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [PW-1:0] ptr);
        rr_pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[idx]) begin
                rr_pick = '0;
                rr_pick[idx] = 1'b1;
            end
        end
    endfunction
    function automatic logic [PW-1:0] next_ptr(input logic [NUM_PORTS-1:0] gnt);
        next_ptr = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (gnt[i]) next_ptr = PW'((i + 1) % NUM_PORTS);
    endfunction
    // {resp, data}; g flags a unit grant, which with a non-arithmetic cmd is an internal inconsistency
    function automatic logic [DATA_W+1:0] calc(input logic [3:0] c, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic g);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return c == 4'd1 ? (s[DATA_W] ? {2'b10, {DATA_W{1'b0}}} : {2'b01, s[DATA_W-1:0]}) :
               c == 4'd2 ? (a < b ? {2'b10, {DATA_W{1'b0}}} : {2'b01, a - b}) :
               c == 4'd5 ? {2'b01, a << b[SHAMT_W-1:0]} :
               c == 4'd6 ? {2'b01, a >> b[SHAMT_W-1:0]} :
               {g ? 2'b11 : 2'b10, {DATA_W{1'b0}}};
    endfunction
    genvar i;
    generate
        for (i = 0; i < NUM_PORTS; i++) begin : g_port
            // armed delays eligibility by one cycle after op2 lands, giving the three-edge latency
            assign rdy[i]       = state[i] == PEND && armed[i];
            assign req_as[i]    = rdy[i] && is_as(cmd_r[i]);
            assign req_sh[i]    = rdy[i] && is_sh(cmd_r[i]);
            assign done[i]      = rdy[i] && (gnt_as[i] || gnt_sh[i] || !(is_as(cmd_r[i]) || is_sh(cmd_r[i])));
            assign port_busy[i] = state[i] != IDLE;
        end
    endgenerate
    assign gnt_as = rr_pick(req_as, ptr_as);
    assign gnt_sh = rr_pick(req_sh, ptr_sh);
    always_ff @(posedge c_clk) begin
        if (reset) begin
            ptr_as   <= '0;
            ptr_sh   <= '0;
            armed    <= '0;
            out_resp <= '0;
            out_data <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                state[p] <= IDLE;
                cmd_r[p] <= '0;
                op1[p]   <= '0;
                op2[p]   <= '0;
            end
        end else begin
            if (|gnt_as) ptr_as <= next_ptr(gnt_as);
            if (|gnt_sh) ptr_sh <= next_ptr(gnt_sh);
            for (int p = 0; p < NUM_PORTS; p++) begin
                {out_resp[2*p +: 2], out_data[DATA_W*p +: DATA_W]} <=
                    done[p] ? calc(cmd_r[p], op1[p], op2[p], gnt_as[p] | gnt_sh[p]) : '0;
                if ((state[p] == IDLE || done[p]) && req_cmd_in[4*p +: 4] != 4'd0) begin
                    cmd_r[p] <= req_cmd_in[4*p +: 4];
                    op1[p]   <= req_data_in[DATA_W*p +: DATA_W];
                    state[p] <= OP2;
                end else if (done[p]) begin
                    state[p] <= IDLE;
                end else if (state[p] == OP2) begin
                    op2[p]   <= req_data_in[DATA_W*p +: DATA_W];
                    armed[p] <= 1'b0;
                    state[p] <= PEND;
                end else if (state[p] == PEND) begin
                    armed[p] <= 1'b1;
                end
            end
        end
    end
endmodule
